// File: rtl/fir_serial_mac.sv
// fir_serial_mac: single-multiplier FIR filter.
// Each accepted sample enters a NUM_OF_TAPS-deep delay line. One multiply-accumulate
// then runs per cycle, and the full-precision y[n] is presented with a one-cycle
// out_valid pulse. The coefficients can be written at runtime while the block is idle.
module fir_serial_mac #(
   parameter int NUM_OF_TAPS = 8,
   parameter int INPUT_WIDTH = 8,
   parameter int COEF_WIDTH  = 8,
   localparam int MULTIPLIED_WIDTH = INPUT_WIDTH + COEF_WIDTH,
   localparam int ADDR_WIDTH       = $clog2(NUM_OF_TAPS),
   localparam int RESULT_WIDTH     = MULTIPLIED_WIDTH + ADDR_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic signed [INPUT_WIDTH-1:0]  input_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [COEF_WIDTH-1:0]   coef_data,
   input  logic [ADDR_WIDTH-1:0]          coef_addr,
   input  logic                           coef_we,
   output logic signed [RESULT_WIDTH-1:0] result,
   output logic                           out_valid
);

   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(NUM_OF_TAPS - 1);
   localparam logic [ADDR_WIDTH:0]   TAP_COUNT = AW1'(NUM_OF_TAPS);

   typedef enum logic {IDLE, MAC} state_t;

   state_t                          state_q, state_d;
   logic signed [INPUT_WIDTH-1:0]   data_q [NUM_OF_TAPS];
   logic signed [COEF_WIDTH-1:0]    coef_q [NUM_OF_TAPS];
   logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic signed [RESULT_WIDTH-1:0]  acc_q, acc_d;
   logic signed [RESULT_WIDTH-1:0]  result_q, result_d;
   logic                            out_valid_q, out_valid_d;
   logic                            accept;
   logic                            coef_wr;
   logic signed [MULTIPLIED_WIDTH-1:0] prod;
   logic signed [RESULT_WIDTH-1:0]  acc_sum;

   // in_ready drops while reset is held, so nothing is handshaken during reset.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign result    = result_q;
   assign out_valid = out_valid_q;

   // Coefficient writes land only while idle and only for an existing tap. Widening
   // the address by one bit keeps the bound check meaningful for any filter length.
   assign coef_wr = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < TAP_COUNT);

   // Single shared multiplier. Both operands are sign-extended to the full
   // product width first, so no bits of the product are lost.
   assign prod    = MULTIPLIED_WIDTH'(data_q[cnt_q]) * MULTIPLIED_WIDTH'(coef_q[cnt_q]);
   assign acc_sum = acc_q + RESULT_WIDTH'(prod);

   // Next-state logic: accept a sample in IDLE, then run one MAC per cycle through all taps.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      result_d    = result_q;
      out_valid_d = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_TAP) begin
               // The last product goes straight into result, so the accumulator
               // never has to be read back one extra cycle.
               result_d    = acc_sum;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register; a reset mid-computation drops the pending output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Accumulator, tap counter and the held output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Sample delay line: data_q[0] is the newest sample, and the line shifts once per accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_OF_TAPS; k++) data_q[k] <= '0;
      end else if (accept) begin
         for (int k = NUM_OF_TAPS - 1; k > 0; k--) data_q[k] <= data_q[k-1];
         data_q[0] <= input_data;
      end
   end

   // Coefficient store. A write on the acceptance edge is seen by that sample's MAC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_OF_TAPS; k++) coef_q[k] <= '0;
      end else if (coef_wr) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac. The main instance uses N=4 and 8/8-bit widths.
// A second instance uses N=5, so that a coefficient address past the last tap can
// actually be driven on the address port.
module tb_fir_serial_mac;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [7:0]  input_data = '0;
   logic               in_valid   = 1'b0;
   logic               in_ready;
   logic signed [7:0]  coef_data  = '0;
   logic [1:0]         coef_addr  = '0;
   logic               coef_we    = 1'b0;
   logic signed [17:0] result;
   logic               out_valid;

   logic               in_valid5  = 1'b0;
   logic               in_ready5;
   logic [2:0]         coef_addr5 = '0;
   logic               coef_we5   = 1'b0;
   logic signed [18:0] result5;
   logic               out_valid5;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic signed [7:0] m_data [N];
   logic signed [7:0] m_coef [N];

   fir_serial_mac #(.NUM_OF_TAPS(N), .INPUT_WIDTH(8), .COEF_WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .input_data(input_data), .in_valid(in_valid),
      .in_ready(in_ready), .coef_data(coef_data), .coef_addr(coef_addr),
      .coef_we(coef_we), .result(result), .out_valid(out_valid));

   fir_serial_mac #(.NUM_OF_TAPS(5), .INPUT_WIDTH(8), .COEF_WIDTH(8)) u_dut5 (
      .clk(clk), .rst(rst), .input_data(input_data), .in_valid(in_valid5),
      .in_ready(in_ready5), .coef_data(coef_data), .coef_addr(coef_addr5),
      .coef_we(coef_we5), .result(result5), .out_valid(out_valid5));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: shift a sample into the delay line and return y[n].
   task automatic model_push(input logic signed [7:0] x, output logic signed [17:0] y);
      int s = 0;
      for (int k = N - 1; k > 0; k--) m_data[k] = m_data[k-1];
      m_data[0] = x;
      for (int k = 0; k < N; k++) s += int'(m_data[k]) * int'(m_coef[k]);
      y = 18'(s);
   endtask

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin m_data[k] = '0; m_coef[k] = '0; end
   endtask

   task automatic load_coefs(input logic signed [7:0] c0, c1, c2, c3);
      logic signed [7:0] c [4];
      c = '{c0, c1, c2, c3};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         coef_we = 1'b1; coef_addr = 2'(k); coef_data = c[k]; m_coef[k] = c[k];
      end
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   // Offer one sample on the main DUT and wait for its output. Returns the result,
   // the number of cycles from acceptance to out_valid, the cycle stamp of acceptance,
   // in_ready as seen alongside out_valid, and the model's expected value.
   task automatic feed(input logic signed [7:0] x, output logic signed [17:0] r,
                       output int lat, output int t0, output logic rdy,
                       output logic signed [17:0] e);
      int g = 0;
      while (!in_ready && g < 40) begin @(negedge clk); g++; end
      in_valid = 1'b1; input_data = x; t0 = cyc;
      model_push(x, e);
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b0; lat = 0;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      r = result; rdy = in_ready;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; input_data = 8'sd7;
      repeat (3) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if (result !== 18'sd0) $display("FAIL reset_result: got %0d expected 0", result);
      else n_pass++;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_no_accept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      else n_pass++;
   endtask

   task automatic test_impulse();
      int exp_y [5] = '{1, 2, 3, 4, 0};
      logic signed [17:0] r, e;
      int lat, t0, prev;
      logic rdy;
      load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         feed((i == 0) ? 8'sd1 : 8'sd0, r, lat, t0, rdy, e);
         n_checks++;
         if (r !== 18'(exp_y[i])) $display("FAIL impulse_y[%0d]: got %0d expected %0d", i, r, exp_y[i]);
         else n_pass++;
         n_checks++;
         if (lat != 4) $display("FAIL impulse_latency[%0d]: got %0d expected 4", i, lat);
         else n_pass++;
         n_checks++;
         if (rdy !== 1'b1) $display("FAIL impulse_ready_with_valid[%0d]: got %b expected 1", i, rdy);
         else n_pass++;
         if (i > 0) begin
            n_checks++;
            if (t0 - prev != 5) $display("FAIL impulse_spacing[%0d]: got %0d expected 5", i, t0 - prev);
            else n_pass++;
         end
         prev = t0;
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL valid_pulse_width: got %b expected 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_extreme();
      logic signed [17:0] r, e;
      int lat, t0;
      logic rdy;
      load_coefs(8'sh80, 8'sh80, 8'sh80, 8'sh80);
      for (int i = 0; i < 4; i++) begin
         feed(8'sh80, r, lat, t0, rdy, e);
         n_checks++;
         if (r !== 18'(16384 * (i + 1)))
            $display("FAIL extreme_y[%0d]: got %0d expected %0d", i, r, 16384 * (i + 1));
         else n_pass++;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (result !== 18'sd65536) $display("FAIL result_held: got %0d expected 65536", result);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic signed [7:0]  d  [3] = '{8'sd1, 8'sd2, 8'sd3};
      logic signed [17:0] ex [3];
      int idx = 0, got = 0, extra = 0;
      logic acc;
      load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      in_valid = 1'b1; input_data = d[0];
      for (int c = 0; c < 80 && got < 3; c++) begin
         acc = 1'b0;
         if (in_valid && in_ready) begin
            model_push(d[idx], ex[idx]);
            idx++; acc = 1'b1;
         end
         @(negedge clk);
         if (acc) begin
            if (idx == 3) in_valid = 1'b0;
            else input_data = d[idx];
         end
         if (out_valid) begin
            n_checks++;
            if (result !== ex[got]) $display("FAIL b2b_y[%0d]: got %0d expected %0d", got, result, ex[got]);
            else n_pass++;
            got++;
         end
      end
      n_checks++;
      if (got != 3 || idx != 3) $display("FAIL b2b_count: outputs %0d accepted %0d expected 3/3", got, idx);
      else n_pass++;
      repeat (12) begin @(negedge clk); if (out_valid) extra++; end
      n_checks++;
      if (extra != 0) $display("FAIL b2b_no_dup: got %0d extra outputs expected 0", extra);
      else n_pass++;
   endtask

   task automatic test_coef_we();
      logic signed [17:0] r, e;
      int lat, t0, g;
      logic rdy;
      // A write during MAC must be ignored.
      g = 0;
      while (!in_ready && g < 40) begin @(negedge clk); g++; end
      in_valid = 1'b1; input_data = 8'sd5;
      model_push(8'sd5, e);
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd10;
      @(negedge clk);
      coef_we = 1'b0; lat = 1;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      n_checks++;
      if (result !== 18'sd21) $display("FAIL mac_write_output: got %0d expected 21", result);
      else n_pass++;
      feed(8'sd1, r, lat, t0, rdy, e);
      n_checks++;
      if (r !== 18'sd28) $display("FAIL mac_write_ignored: got %0d expected 28", r);
      else n_pass++;
      // A write on the same idle edge as acceptance is used by that sample.
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 2'd3; coef_data = -8'sd7; m_coef[3] = -8'sd7;
      feed(8'sd2, r, lat, t0, rdy, e);
      n_checks++;
      if (r !== -18'sd2) $display("FAIL same_edge_write: got %0d expected -2", r);
      else n_pass++;
   endtask

   task automatic test_addr_range();
      int lat, g;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         coef_we5 = 1'b1; coef_addr5 = 3'(k);
         coef_data = (k < 5) ? 8'(k + 1) : 8'sd99;
      end
      @(negedge clk);
      coef_we5 = 1'b0;
      for (int s = 0; s < 5; s++) begin
         g = 0;
         while (!in_ready5 && g < 40) begin @(negedge clk); g++; end
         in_valid5 = 1'b1; input_data = (s == 0) ? 8'sd1 : 8'sd0;
         @(negedge clk);
         in_valid5 = 1'b0; lat = 0;
         while (!out_valid5 && lat < 20) begin @(negedge clk); lat++; end
         n_checks++;
         if (result5 !== 19'(s + 1)) $display("FAIL addr_range_y[%0d]: got %0d expected %0d", s, result5, s + 1);
         else n_pass++;
         n_checks++;
         if (lat != 5) $display("FAIL addr_range_latency[%0d]: got %0d expected 5", s, lat);
         else n_pass++;
      end
   endtask

   // Start a sample, assert reset in its second MAC cycle, and confirm that nothing emerges.
   task automatic abort_mac();
      int g = 0, seen = 0;
      while (!in_ready && g < 40) begin @(negedge clk); g++; end
      in_valid = 1'b1; input_data = 8'sd9;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || result !== 18'sd0 || in_ready !== 1'b0)
         $display("FAIL abort_reset_state: out_valid=%b result=%0d in_ready=%b expected 0/0/0",
                  out_valid, result, in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      repeat (8) begin @(negedge clk); if (out_valid) seen++; end
      n_checks++;
      if (seen != 0 || in_ready !== 1'b1)
         $display("FAIL abort_no_output: pulses=%0d in_ready=%b expected 0/1", seen, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid_mac();
      logic signed [17:0] r, e;
      int lat, t0;
      logic rdy;
      abort_mac();
      // With the coefficients cleared, every output is zero even once all taps hold data.
      for (int i = 0; i < 4; i++) begin
         feed(8'sd1, r, lat, t0, rdy, e);
         n_checks++;
         if (r !== 18'sd0) $display("FAIL coefs_cleared[%0d]: got %0d expected 0", i, r);
         else n_pass++;
      end
      load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      abort_mac();
      load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
      for (int i = 0; i < 4; i++) begin
         feed((i == 0) ? 8'sd1 : 8'sd0, r, lat, t0, rdy, e);
         n_checks++;
         if (r !== 18'(i + 1)) $display("FAIL no_stale_history[%0d]: got %0d expected %0d", i, r, i + 1);
         else n_pass++;
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_impulse();
      test_extreme();
      test_back_to_back();
      test_coef_we();
      test_addr_range();
      test_reset_mid_mac();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
